hazard_pipe_track: RTL

Pipeline-register bank that consumes the hazard unit's `stall` request and produces the per-stage hazard-tracking signals the hazard unit reads: `E_Tnew/E_a3/E_we`, `M_Tnew/M_a3/M_we` and the W-stage equivalents.

It holds the F/D, D/E, E/M and M/W registers for instruction, PC and writeback metadata. On a stall it freezes the F/D register and inserts a bubble into D/E. At each stage boundary it decrements `Tnew`, saturating at 0.

---
 rtl/hazard_pipe_track_pkg.sv | 26 ++
 rtl/hazard_pipe_track_stage_reg.sv | 28 ++
 rtl/hazard_pipe_track.sv | 79 +++++++
 3 files changed

// File: rtl/hazard_pipe_track_pkg.sv
// hazard_pipe_track_pkg: shared constants, stage record and Tnew helpers for the pipeline tracker
package hazard_pipe_track_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int TNEW_W = 2;
  localparam int REG_W = 5;
  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic              valid;
    logic [TNEW_W-1:0] tnew;
    logic [REG_W-1:0]  a3;
    logic              we;
  } stage_t;
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction
  // a bubble keeps the PC so later stages still see a meaningful address
  function automatic stage_t bubble(input logic [31:0] pc);
    stage_t s;
    s = '0;
    s.instr = NOP;
    s.pc = pc;
    return s;
  endfunction
endpackage

// File: rtl/hazard_pipe_track_stage_reg.sv
// pipe_stage_reg: one pipeline register with hold, bubble insert and optional saturating Tnew decrement
module pipe_stage_reg
  import hazard_pipe_track_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter bit          DEC      = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   clr,
  input  stage_t d_i,
  output stage_t q_o
);
  stage_t q_q, q_d;
  // next value: bubble on clr, otherwise age Tnew and drop writes to $0
  always_comb begin
    q_d = d_i;
    q_d.tnew = DEC ? tnew_dec(d_i.tnew) : d_i.tnew;
    q_d.we = d_i.we && (d_i.a3 != '0);
    q_d = clr ? bubble(d_i.pc) : q_d;
  end
  // state register, held when en is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= bubble(RESET_PC);
    else if (en) q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/hazard_pipe_track.sv
// hazard_pipe_track: F/D, D/E, E/M, M/W registers carrying hazard-tracking metadata
module hazard_pipe_track
  import hazard_pipe_track_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       F_instr,
  input  logic [31:0]       F_pc,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic [REG_W-1:0]  D_a3,
  input  logic              D_we,
  output logic [31:0]       D_instr,
  output logic [31:0]       D_pc,
  output logic [31:0]       E_instr,
  output logic [31:0]       M_instr,
  output logic [31:0]       W_instr,
  output logic [31:0]       E_pc,
  output logic [31:0]       M_pc,
  output logic [31:0]       W_pc,
  output logic              E_valid,
  output logic              M_valid,
  output logic              W_valid,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic [TNEW_W-1:0] W_Tnew,
  output logic [REG_W-1:0]  E_a3,
  output logic [REG_W-1:0]  M_a3,
  output logic [REG_W-1:0]  W_a3,
  output logic              E_we,
  output logic              M_we,
  output logic              W_we
);
  stage_t fd_d, fd_q, de_d, de_q, em_q, mw_q;
  // fetch record entering F/D
  always_comb begin
    fd_d = bubble(F_pc);
    fd_d.instr = F_instr;
    fd_d.valid = 1'b1;
  end
  // decode record: F/D contents plus this cycle's decoded writeback metadata
  always_comb begin
    de_d = fd_q;
    de_d.valid = 1'b1;
    de_d.tnew = D_Tnew;
    de_d.a3 = D_a3;
    de_d.we = D_we;
  end
  pipe_stage_reg #(.RESET_PC(RESET_PC), .DEC(1'b0)) u_fd (
    .clk(clk), .rst_n(rst_n), .en(~stall), .clr(1'b0), .d_i(fd_d), .q_o(fd_q));
  pipe_stage_reg #(.RESET_PC(RESET_PC), .DEC(1'b0)) u_de (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(stall), .d_i(de_d), .q_o(de_q));
  pipe_stage_reg #(.RESET_PC(RESET_PC), .DEC(1'b1)) u_em (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .d_i(de_q), .q_o(em_q));
  pipe_stage_reg #(.RESET_PC(RESET_PC), .DEC(1'b1)) u_mw (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .d_i(em_q), .q_o(mw_q));
  assign D_instr = fd_q.instr;
  assign D_pc    = fd_q.pc;
  assign E_instr = de_q.instr;
  assign E_pc    = de_q.pc;
  assign E_valid = de_q.valid;
  assign E_Tnew  = de_q.tnew;
  assign E_a3    = de_q.a3;
  assign E_we    = de_q.we;
  assign M_instr = em_q.instr;
  assign M_pc    = em_q.pc;
  assign M_valid = em_q.valid;
  assign M_Tnew  = em_q.tnew;
  assign M_a3    = em_q.a3;
  assign M_we    = em_q.we;
  assign W_instr = mw_q.instr;
  assign W_pc    = mw_q.pc;
  assign W_valid = mw_q.valid;
  assign W_Tnew  = mw_q.tnew;
  assign W_a3    = mw_q.a3;
  assign W_we    = mw_q.we;
endmodule
